// File: rtl/eth_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_scheduler
// Brief    : Two-source round-robin frame scheduler that buffers one UDP payload
//            and hands it to a nibble-clock Ethernet transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_scheduler #(
    parameter int PAYLOAD_BYTES  = 18,
    parameter int IFG_CYCLES     = 24,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  src_req,
    input  logic [1:0]  src_valid,
    input  logic [7:0]  src_data0,
    input  logic [7:0]  src_data1,
    output logic [1:0]  src_ready,
    output logic [1:0]  src_done,
    output logic [1:0]  grant,
    output logic        tx_start,
    input  logic        tx_done,
    output logic        tx_abort,
    input  logic [4:0]  tx_rd_addr,
    output logic [7:0]  tx_rd_data,
    output logic        busy,
    output logic        err_timeout,
    output logic [15:0] frames_sent
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_IFG       = 3'd4
    } state_t;

    localparam logic [4:0]  NUM_BYTES    = 5'(PAYLOAD_BYTES);
    localparam logic [4:0]  LAST_BYTE    = 5'(PAYLOAD_BYTES - 1);
    localparam logic [11:0] TIMEOUT_LAST = 12'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  IFG_LAST     = 8'(IFG_CYCLES - 1);

    state_t      r_state;
    logic [4:0]  r_wr_ptr;
    logic [11:0] r_to_cnt;
    logic [7:0]  r_ifg_cnt;
    logic        r_last_src;
    logic [7:0]  r_buf [0:31];

    logic       w_sel;
    logic       w_pick;
    logic [7:0] w_byte;
    logic       w_accept;

    assign w_sel    = grant[1];
    // Alternate only on contention; a lone requester always wins.
    assign w_pick   = (src_req == 2'b11) ? ~r_last_src : src_req[1];
    assign w_byte   = w_sel ? src_data1 : src_data0;
    assign w_accept = (r_state == S_LOAD) && src_req[w_sel]
                      && src_valid[w_sel] && src_ready[w_sel];
    assign busy     = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wr_ptr] <= w_byte;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= 5'd0;
            r_to_cnt    <= 12'd0;
            r_ifg_cnt   <= 8'd0;
            r_last_src  <= 1'b1;
            grant       <= 2'b00;
            src_ready   <= 2'b00;
            src_done    <= 2'b00;
            tx_start    <= 1'b0;
            tx_abort    <= 1'b0;
            tx_rd_data  <= 8'h00;
            err_timeout <= 1'b0;
            frames_sent <= 16'd0;
        end else begin
            src_done   <= 2'b00;
            tx_start   <= 1'b0;
            tx_abort   <= 1'b0;
            tx_rd_data <= (tx_rd_addr < NUM_BYTES) ? r_buf[tx_rd_addr] : 8'h00;

            case (r_state)
                S_IDLE: begin
                    if (en && (src_req != 2'b00)) begin
                        grant      <= {w_pick, ~w_pick};
                        src_ready  <= {w_pick, ~w_pick};
                        r_last_src <= w_pick;
                        r_wr_ptr   <= 5'd0;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!src_req[w_sel]) begin
                        grant     <= 2'b00;
                        src_ready <= 2'b00;
                        r_state   <= S_IDLE;
                    end else if (w_accept) begin
                        r_wr_ptr <= r_wr_ptr + 5'd1;
                        if (r_wr_ptr == LAST_BYTE) begin
                            src_ready <= 2'b00;
                            tx_start  <= 1'b1;
                            r_state   <= S_START;
                        end
                    end
                end
                S_START: begin
                    r_to_cnt <= 12'd0;
                    r_state  <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // A completion arriving on the timeout cycle still counts as sent.
                    if (tx_done) begin
                        src_done    <= grant;
                        frames_sent <= frames_sent + 16'd1;
                        r_ifg_cnt   <= 8'd0;
                        r_state     <= S_IFG;
                    end else if (r_to_cnt == TIMEOUT_LAST) begin
                        tx_abort    <= 1'b1;
                        src_done    <= grant;
                        err_timeout <= 1'b1;
                        r_ifg_cnt   <= 8'd0;
                        r_state     <= S_IFG;
                    end else begin
                        r_to_cnt <= r_to_cnt + 12'd1;
                    end
                end
                S_IFG: begin
                    if (r_ifg_cnt == IFG_LAST) begin
                        grant   <= 2'b00;
                        r_state <= S_IDLE;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_scheduler
// Brief    : Self-checking bench for eth_tx_scheduler with a payload scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_tx_scheduler;

    localparam int PAYLOAD_BYTES  = 18;
    localparam int IFG_CYCLES     = 24;
    localparam int TIMEOUT_CYCLES = 4095;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [1:0]  src_req;
    logic [1:0]  src_valid;
    logic [7:0]  src_data0;
    logic [7:0]  src_data1;
    logic [1:0]  src_ready;
    logic [1:0]  src_done;
    logic [1:0]  grant;
    logic        tx_start;
    logic        tx_done;
    logic        tx_abort;
    logic [4:0]  tx_rd_addr;
    logic [7:0]  tx_rd_data;
    logic        busy;
    logic        err_timeout;
    logic [15:0] frames_sent;

    typedef struct packed {
        logic [1:0]   g;
        logic [255:0] data;
    } frame_t;

    frame_t      exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [15:0] exp_frames = 16'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eth_tx_scheduler #(
        .PAYLOAD_BYTES (PAYLOAD_BYTES),
        .IFG_CYCLES    (IFG_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .src_req    (src_req),
        .src_valid  (src_valid),
        .src_data0  (src_data0),
        .src_data1  (src_data1),
        .src_ready  (src_ready),
        .src_done   (src_done),
        .grant      (grant),
        .tx_start   (tx_start),
        .tx_done    (tx_done),
        .tx_abort   (tx_abort),
        .tx_rd_addr (tx_rd_addr),
        .tx_rd_data (tx_rd_data),
        .busy       (busy),
        .err_timeout(err_timeout),
        .frames_sent(frames_sent)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        src_req   = 2'b00;
        src_valid = 2'b00;
        tx_done   = 1'b0;
        tick();
        tick();
        reset      = 1'b0;
        exp_frames = 16'd0;
        exp_q.delete();
    endtask

    // Request, stream one payload, check tx_start, then read the buffer back.
    task automatic run_frame(input int src, input logic [7:0] base,
                             output int wait_n, output int start_cyc);
        logic [1:0] oh;
        logic [7:0] exp_b;
        frame_t     f;
        int         n;
        oh = (src == 1) ? 2'b10 : 2'b01;
        src_req[src] = 1'b1;
        n = 0;
        while (grant == 2'b00 && n < 200) begin
            tick();
            n++;
        end
        wait_n = n;
        n_checks++;
        if (grant !== oh) begin
            n_fail++;
            $display("FAIL grant_win: got %b expected %b", grant, oh);
        end
        n_checks++;
        if (src_ready !== oh) begin
            n_fail++;
            $display("FAIL src_ready_load: got %b expected %b", src_ready, oh);
        end
        f.g    = oh;
        f.data = '0;
        src_valid = 2'b11;
        for (int k = 0; k < PAYLOAD_BYTES; k++) begin
            if (src == 1) begin
                src_data1 = base + 8'(k);
                src_data0 = 8'hEE;
            end else begin
                src_data0 = base + 8'(k);
                src_data1 = 8'hEE;
            end
            f.data[k*8 +: 8] = base + 8'(k);
            tick();
        end
        src_valid = 2'b00;
        exp_q.push_back(f);
        n_checks++;
        if (tx_start !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_start_after_last: got %b expected 1", tx_start);
        end
        n_checks++;
        if (src_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL src_ready_drop: got %b expected 00", src_ready);
        end
        start_cyc = cyc;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        f = exp_q.pop_front();
        n_checks++;
        if (grant !== f.g) begin
            n_fail++;
            $display("FAIL grant_at_start: got %b expected %b", grant, f.g);
        end
        for (int a = 0; a < 32; a++) begin
            if (a > PAYLOAD_BYTES && a != 31) continue;
            tx_rd_addr = 5'(a);
            tick();
            exp_b = (a < PAYLOAD_BYTES) ? f.data[a*8 +: 8] : 8'h00;
            n_checks++;
            if (tx_rd_data !== exp_b) begin
                n_fail++;
                $display("FAIL rd_data[%0d]: got %h expected %h", a, tx_rd_data, exp_b);
            end
            if (a == 0) begin
                n_checks++;
                if (tx_start !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tx_start_pulse: got %b expected 0", tx_start);
                end
            end
        end
    endtask

    // Pulse tx_done, check completion, then measure the busy tail of the IFG.
    task automatic finish_done(input logic [1:0] oh, input bit keep_req, output int ifg_n);
        int n;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        if (!keep_req) src_req = 2'b00;
        exp_frames = exp_frames + 16'd1;
        n_checks++;
        if (src_done !== oh) begin
            n_fail++;
            $display("FAIL src_done: got %b expected %b", src_done, oh);
        end
        n_checks++;
        if (frames_sent !== exp_frames) begin
            n_fail++;
            $display("FAIL frames_sent: got %0d expected %0d", frames_sent, exp_frames);
        end
        n_checks++;
        if (tx_abort !== 1'b0 || grant !== oh) begin
            n_fail++;
            $display("FAIL done_abort_grant: got %b/%b expected 0/%b", tx_abort, grant, oh);
        end
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
            if (n == 1) begin
                n_checks++;
                if (src_done !== 2'b00) begin
                    n_fail++;
                    $display("FAIL src_done_pulse: got %b expected 00", src_done);
                end
            end
        end
        ifg_n = n;
    endtask

    task automatic test_reset();
        en         = 1'b0;
        src_data0  = 8'h00;
        src_data1  = 8'h00;
        tx_rd_addr = 5'd0;
        do_reset();
        n_checks++;
        if ({grant, src_ready, src_done, tx_start, tx_abort, busy, err_timeout} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0", {grant, src_ready, src_done, tx_start, tx_abort, busy, err_timeout});
        end
        n_checks++;
        if (frames_sent !== 16'd0 || tx_rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h expected 0000/00", frames_sent, tx_rd_data);
        end
    endtask

    task automatic test_basic();
        int w, s, ifg;
        en = 1'b1;
        src_req = 2'b01;
        run_frame(0, 8'h00, w, s);
        n_checks++;
        if (w !== 1) begin
            n_fail++;
            $display("FAIL basic_grant_latency: got %0d expected 1", w);
        end
        finish_done(2'b01, 1'b0, ifg);
        n_checks++;
        if (ifg !== IFG_CYCLES) begin
            n_fail++;
            $display("FAIL basic_ifg: got %0d expected %0d", ifg, IFG_CYCLES);
        end
    endtask

    task automatic test_abort_load();
        int  n;
        bit  saw_start;
        bit  saw_done;
        src_req = 2'b01;
        n = 0;
        while (grant == 2'b00 && n < 50) begin
            tick();
            n++;
        end
        src_valid = 2'b01;
        for (int k = 0; k < 7; k++) begin
            src_data0 = 8'hA0 + 8'(k);
            tick();
        end
        src_req   = 2'b00;
        src_valid = 2'b00;
        tick();
        n_checks++;
        if (grant !== 2'b00 || busy !== 1'b0 || src_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL load_abort_idle: got %b/%b/%b expected 00/0/00", grant, busy, src_ready);
        end
        saw_start = 1'b0;
        saw_done  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (tx_start) saw_start = 1'b1;
            if (src_done != 2'b00) saw_done = 1'b1;
            tick();
        end
        n_checks++;
        if (saw_start !== 1'b0 || saw_done !== 1'b0 || frames_sent !== exp_frames) begin
            n_fail++;
            $display("FAIL load_abort_quiet: got %b/%b/%0d expected 0/0/%0d", saw_start, saw_done, frames_sent, exp_frames);
        end
    endtask

    task automatic test_enable();
        int w, s, ifg;
        en      = 1'b0;
        src_req = 2'b01;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        n_checks++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL en_block: got %b/%b expected 00/0", grant, busy);
        end
        n_checks++;
        if (frames_sent !== exp_frames || src_done !== 2'b00) begin
            n_fail++;
            $display("FAIL stray_tx_done: got %0d/%b expected %0d/00", frames_sent, src_done, exp_frames);
        end
        en = 1'b1;
        tick();
        n_checks++;
        if (grant !== 2'b01) begin
            n_fail++;
            $display("FAIL en_grant: got %b expected 01", grant);
        end
        en = 1'b0;
        run_frame(0, 8'h30, w, s);
        finish_done(2'b01, 1'b0, ifg);
        n_checks++;
        if (ifg !== IFG_CYCLES) begin
            n_fail++;
            $display("FAIL en_low_ifg: got %0d expected %0d", ifg, IFG_CYCLES);
        end
        en = 1'b1;
    endtask

    task automatic test_round_robin();
        int w, s, ifg;
        do_reset();
        en      = 1'b1;
        src_req = 2'b11;
        run_frame(0, 8'h40, w, s);
        finish_done(2'b01, 1'b1, ifg);
        n_checks++;
        if (ifg !== IFG_CYCLES) begin
            n_fail++;
            $display("FAIL rr_ifg: got %0d expected %0d", ifg, IFG_CYCLES);
        end
        run_frame(1, 8'h80, w, s);
        n_checks++;
        if (w !== 1) begin
            n_fail++;
            $display("FAIL rr_regrant_latency: got %0d expected 1", w);
        end
        finish_done(2'b10, 1'b1, ifg);
        run_frame(0, 8'hC0, w, s);
        finish_done(2'b01, 1'b0, ifg);
    endtask

    task automatic test_done_at_timeout();
        int w, s, ifg;
        do_reset();
        en      = 1'b1;
        src_req = 2'b01;
        run_frame(0, 8'h11, w, s);
        while ((cyc - s) < TIMEOUT_CYCLES) tick();
        finish_done(2'b01, 1'b0, ifg);
        n_checks++;
        if (err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL done_wins_err: got %b expected 0", err_timeout);
        end
    endtask

    task automatic test_timeout();
        int w, s, n;
        src_req = 2'b01;
        run_frame(0, 8'h22, w, s);
        while (tx_abort !== 1'b1 && (cyc - s) < TIMEOUT_CYCLES + 50) tick();
        src_req = 2'b00;
        n_checks++;
        if ((cyc - s) !== TIMEOUT_CYCLES + 1 || tx_abort !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_latency: got %0d/%b expected %0d/1", cyc - s, tx_abort, TIMEOUT_CYCLES + 1);
        end
        n_checks++;
        if (src_done !== 2'b01 || err_timeout !== 1'b1 || frames_sent !== exp_frames) begin
            n_fail++;
            $display("FAIL abort_status: got %b/%b/%0d expected 01/1/%0d", src_done, err_timeout, frames_sent, exp_frames);
        end
        tick();
        n_checks++;
        if (tx_abort !== 1'b0 || src_done !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_pulse: got %b/%b expected 0/00", tx_abort, src_done);
        end
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        n_checks++;
        if (busy !== 1'b0 || err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b/%b expected 0/1", busy, err_timeout);
        end
    endtask

    task automatic test_reset_midframe();
        int w, s;
        src_req = 2'b01;
        run_frame(0, 8'h55, w, s);
        tx_rd_addr = 5'd5;
        tick();
        n_checks++;
        if (tx_rd_data !== 8'h5A || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got %h/%b expected 5a/1", tx_rd_data, busy);
        end
        #2;
        reset   = 1'b1;
        tx_done = 1'b1;
        #1;
        n_checks++;
        if ({grant, src_ready, src_done, tx_start, tx_abort, busy, err_timeout} !== 10'd0) begin
            n_fail++;
            $display("FAIL async_reset_ctrl: got %b expected 0", {grant, src_ready, src_done, tx_start, tx_abort, busy, err_timeout});
        end
        n_checks++;
        if (frames_sent !== 16'd0 || tx_rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset_data: got %h/%h expected 0000/00", frames_sent, tx_rd_data);
        end
        tick();
        n_checks++;
        if (tx_abort !== 1'b0 || src_done !== 2'b00 || frames_sent !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_at_done: got %b/%b/%h expected 0/00/0000", tx_abort, src_done, frames_sent);
        end
        tx_done = 1'b0;
        src_req = 2'b00;
        reset   = 1'b0;
        exp_frames = 16'd0;
        exp_q.delete();
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        src_req   = 2'b00;
        src_valid = 2'b00;
        tx_done   = 1'b0;
        test_reset();
        test_basic();
        test_abort_load();
        test_enable();
        test_round_robin();
        test_done_at_timeout();
        test_timeout();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
